// File: rtl/mul_unit.sv
// RISC-V M-extension multiply stage with two pipeline registers and valid/ready handshakes.
// Signs are stripped before the unsigned Mutiplier array and put back after the product register.
module mul_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_tag
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic        s1_valid;
    logic [31:0] s1_mag_a;
    logic [31:0] s1_mag_b;
    logic        s1_neg;
    logic [1:0]  s1_op;
    logic [4:0]  s1_tag;

    logic        s2_valid;
    logic [63:0] s2_prod;
    logic        s2_neg;
    logic [1:0]  s2_op;
    logic [4:0]  s2_tag;

    logic        adv1;
    logic        adv2;
    logic        accept;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod;
    logic [63:0] p_fix;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 && !flush;
    assign accept   = in_valid && in_ready;

    // Only operands treated as signed contribute a sign; MUL and MULHU stay unsigned.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        if ((in_op == OP_MULH) || (in_op == OP_MULHSU)) begin
            sign_a = in_a[31];
        end
        if (in_op == OP_MULH) begin
            sign_b = in_b[31];
        end
        mag_a = sign_a ? (~in_a + 32'd1) : in_a;
        mag_b = sign_b ? (~in_b + 32'd1) : in_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mag_a <= '0;
            s1_mag_b <= '0;
            s1_neg   <= 1'b0;
            s1_op    <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_mag_a <= mag_a;
                s1_mag_b <= mag_b;
                s1_neg   <= sign_a ^ sign_b;
                s1_op    <= in_op;
                s1_tag   <= in_tag;
            end
        end
    end

    Mutiplier u_mult (
        .a    (s1_mag_a),
        .b    (s1_mag_b),
        .prod (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_neg   <= 1'b0;
            s2_op    <= '0;
            s2_tag   <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= prod;
                s2_neg  <= s1_neg;
                s2_op   <= s1_op;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Negation sits after S2 so the array alone fills the S1->S2 path; -0 wraps to 0.
    always_comb begin
        p_fix      = s2_neg ? (~s2_prod + 64'd1) : s2_prod;
        out_result = (s2_op == OP_MUL) ? p_fix[31:0] : p_fix[63:32];
    end

    assign out_valid = s2_valid;
    assign out_tag   = s2_tag;

endmodule

// Combinational 32x32 unsigned array multiplier: shifted partial products accumulated row by row.
module Mutiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod
);

    always_comb begin
        prod = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                prod = prod + ({32'd0, a} << i);
            end
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: vector table, streaming, backpressure, flush, reset and a random run,
// all scored through a queue of expected results filled at accept time.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } sb_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[10];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] cur_res = '0;
    bit          cur_lat = 1'b0;
    logic [31:0] held;

    mul_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: sign/zero-extend to 66 bits and multiply.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] p;
        ea = {{34{((op == 2'b01) || (op == 2'b10)) && a[31]}}, a};
        eb = {{34{(op == 2'b01) && b[31]}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Scoreboard: outputs and accepts are both decided by what is seen before the next rising edge.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: actual tag=%0d result=%h required=no output",
                             out_tag, out_result);
                end else begin
                    e = sb.pop_front();
                    total--;
                    chk("out_result", out_result, e.res);
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
                end
            end
            if (flush) sb.delete();
            if (in_valid && in_ready) begin
                e.res = cur_res;
                e.tag = in_tag;
                e.acc = cyc;
                e.lat = cur_lat;
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input bit lat);
        bit got;
        got      = 1'b0;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        cur_res  = exp;
        cur_lat  = lat;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: actual=never accepted required=accepted tag=%0d", tag);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'd7,         32'd6,         32'h0000_002A};
        vecs[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[6] = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[7] = '{2'b01, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
        vecs[8] = '{2'b10, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF};
        vecs[9] = '{2'b10, 32'd2,         32'h8000_0000, 32'h0000_0001};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Vector table, full throughput, latency checked
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].exp, 1'b1);
        end
        drain();
        step();

        // Streaming: eight back-to-back ops, eight consecutive results
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                in_op    = 2'b00;
                in_a     = 32'(i + 1);
                in_b     = 32'(i + 3);
                in_tag   = 5'(i);
                cur_res  = 32'((i + 1) * (i + 3));
                cur_lat  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_tag", 32'(out_tag), 32'(i - 2));
            end
            step();
        end
        drain();

        // Backpressure: two ops fill the pipe, the third waits for out_ready
        out_ready = 1'b0;
        issue(2'b00, 32'd3, 32'd5, 5'd20, 32'd15, 1'b0);
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'd1, 1'b0);
        in_op    = 2'b01;
        in_a     = 32'hFFFF_FFFD;
        in_b     = 32'd5;
        in_tag   = 5'd22;
        cur_res  = 32'hFFFF_FFFF;
        cur_lat  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head_result", out_result, 32'd15);
        held = out_result;
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            chk("bp_hold_result", out_result, held);
            chk("bp_hold_tag", 32'(out_tag), 32'd20);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        drain();
        step();

        // Flush with both stages full and output stalled
        out_ready = 1'b0;
        issue(2'b00, 32'd9, 32'd9, 5'd3, 32'd81, 1'b0);
        issue(2'b00, 32'd4, 32'd4, 5'd4, 32'd16, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 32'd100;
        in_b     = 32'd100;
        in_tag   = 5'd9;
        cur_res  = 32'd10000;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_out_valid", 32'(out_valid), 32'd0);
            step();
        end
        issue(2'b11, 32'h8000_0000, 32'd4, 5'd11, 32'd2, 1'b1);
        drain();
        step();

        // Random mix with random backpressure, reference model expectations
        for (int i = 0; i < 150; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            in_b      = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            in_tag    = 5'(i);
            cur_res   = ref_mul(in_op, in_a, in_b);
            cur_lat   = 1'b0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = 2'b11;
            in_a     = 32'hFFFF_0000 + 32'(i);
            in_b     = 32'hFFFF_FFF0;
            in_tag   = 5'(24 + i);
            cur_res  = ref_mul(in_op, in_a, in_b);
            cur_lat  = 1'b1;
            step();
        end
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_result", out_result, 32'd0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        step();
        step();
        #2 rst_n = 1'b1;
        #1;
        chk("arst_rel_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_stale", 32'(out_valid), 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "timeout");
    end

endmodule
